fmap_window_ctrl: RTL and testbench
===================================

# fmap_window_ctrl

Raster-scan sequencer for the input feature-map shift register of a conv layer. Accepts the unpadded pixel stream (one D-bit pixel-depth vector per beat, row-major), inserts zero padding, issues one shift-enable per padded element, and flags each cycle in which the shift register holds a complete, stride-aligned FH×FW window. It also reports the window's output coordinates. It sits between the upstream layer output and the shift-register/PE array pair and replaces free-running fill counting with per-window qualification.

## Interface
Parameters:
- H, 32: unpadded map height
- W, 128: unpadded map width
- D, 512: pixel depth (bits per beat)
- FH, 3: window height
- FW, 3: window width
- PAD, 1: zero border on each side
- STRIDE_H, 1: vertical window stride
- STRIDE_W, 1: horizontal window stride
- Derived localparams:
  - HP = H+2*PAD
  - WP = W+2*PAD
  - OH = (HP-FH)/STRIDE_H+1
  - OW = (WP-FW)/STRIDE_W+1
  - RW = max(1,$clog2(OH))
  - CW = max(1,$clog2(OW))

Ports:
- clk, in, 1: clock
- rst, in, 1: reset. One clock; reset is synchronous and active-high.
- start, in, 1: begin a frame. Sampled only in IDLE.
- in_valid, in, 1: upstream pixel valid
- in_data, in, D: upstream pixel
- in_ready, out, 1: pixel accepted this cycle
- sr_en, out, 1: shift enable to the shift register
- sr_data, out, D: shift-register input (pixel or zero)
- win_valid, out, 1: shift register holds a valid window
- win_ready, in, 1: consumer takes the window
- win_row, out, RW: output row index of the current window
- win_col, out, CW: output column index of the current window
- busy, out, 1: frame in progress
- done, out, 1: one-cycle pulse after the last window is taken

## Operation
- States:
  - IDLE → RUN on start.
  - RUN → LAST after the element at padded position (HP-1, WP-1) is shifted.
  - LAST → DONE when win_valid is low, or win_valid && win_ready.
  - DONE → IDLE unconditionally; done=1 for that single cycle.
- Padded position counters: r in 0..HP-1, c in 0..WP-1. Cleared on start. They advance by one, raster order, on every sr_en.
- Pad position: r<PAD, r≥PAD+H, c<PAD, or c≥PAD+W.
- Stall = win_valid && !win_ready. While stalled, sr_en=0 and in_ready=0.
- RUN, not stalled, pad position: sr_en=1, sr_data=0, in_ready=0. No input is consumed.
- RUN, not stalled, data position: in_ready=1, sr_en=in_valid, sr_data=in_data.
- in_ready, sr_en and sr_data are combinational from state, counters and in_valid. Pixel acceptance and the shift happen at the same edge.
- Window qualification on a shift of element (r, c): the window is valid when all of the following hold:
  - r≥FH-1
  - c≥FW-1
  - vertical phase counter = 0
  - horizontal phase counter = 0
- Phase counters:
  - Vertical counter counts rows since r=FH-1, modulo STRIDE_H.
  - Horizontal counter counts columns since c=FW-1, modulo STRIDE_W; it resets each row.
  - No divider is used.
- win_row/win_col are output-index counters. They advance on each qualified window, row-major, OW per row.
- Outputs outside RUN/LAST:
  - sr_en=0 and in_ready=0.
  - sr_data=0 whenever sr_en=0.
- start while busy is ignored.
- Stale shift-register contents from a previous frame are never flagged: qualification depends only on the current frame's counters.

## Timing
- Reset values: state IDLE; in_ready, sr_en, win_valid, busy, done = 0; sr_data, win_row, win_col, and all counters = 0.
- busy=1 in RUN and LAST. It goes high the cycle after start is sampled.
- win_valid is registered. It rises one cycle after the qualifying sr_en edge, aligned with the updated shift-register contents.
- win_valid falls on win_valid && win_ready, unless a new qualifying shift occurs at that same edge; in that case it stays high.
- A qualifying shift and a window hand-off at the same edge are legal. This gives back-to-back windows at one per cycle with no bubble.
- A frame takes HP·WP shifts plus stall and in_valid gap cycles.
- rst mid-frame: all state returns to reset values on the next edge. A partial frame is abandoned and done is not pulsed.

## Structure
- Shared layer-geometry package holds HP, WP, OH, OW and the safe clog2 width function. The geometry is reused by the shift register and the output buffer.
- Natural sub-module: fmap_raster_cnt, a parameterised (rows, cols) raster counter with wrap and last-element flags. It is instantiated once for padded (r, c) and once for output (win_row, win_col).
- Stride-phase counters and the FSM stay in the top module.

## Test plan
- H=W=4, PAD=1, FH=FW=3, stride 1, in_valid=1, win_ready=1:
  - 36 sr_en pulses, 16 of which carry data (in_ready beats).
  - 16 windows.
  - First win_valid one cycle after the 15th sr_en, with win_row=0, win_col=0.
  - Single done pulse.
- Same geometry with STRIDE_H=STRIDE_W=2:
  - Exactly 4 windows, indices (0,0), (0,1), (1,0), (1,1).
  - Windows after the 15th, 17th, 27th and 29th shifts.
- PAD=0, H=W=4, FH=FW=3:
  - 16 sr_en pulses, all data, no zero beats.
  - 4 windows.
- Random in_valid gaps plus win_ready low for 5 cycles on window 3:
  - No sr_en or in_ready during the stall.
  - Window 3's win_row/win_col held stable.
  - Total window count unchanged.
- rst asserted at shift 20 of a frame, then start again:
  - All outputs 0 the cycle after rst.
  - No done pulse for the abandoned frame.
  - New frame produces the full 16 windows.
- start pulsed during RUN:
  - Ignored.
  - The frame completes with exactly one done.

Source files
------------

// File: rtl/fmap_window_ctrl_pkg.sv
// Shared layer geometry helpers and sequencer state encoding for the feature-map window path.
package fmap_window_ctrl_pkg;

    // Sequencer states
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StLast = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    // Counter width that stays at least one bit for degenerate sizes
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Map extent once the zero border is added on both sides
    function automatic int unsigned padded_dim(input int unsigned n, input int unsigned pad);
        return n + 2 * pad;
    endfunction

    // Number of window positions along one padded axis
    function automatic int unsigned out_dim(input int unsigned np, input int unsigned f,
                                            input int unsigned stride);
        return (np - f) / stride + 1;
    endfunction

endpackage

// File: rtl/fmap_raster_cnt.sv
// Row-major (row, col) counter with column-wrap and last-element flags.
module fmap_raster_cnt
    import fmap_window_ctrl_pkg::*;
#(
    parameter int unsigned Rows = 4,
    parameter int unsigned Cols = 4,
    parameter int unsigned RowW = safe_clog2(Rows),
    parameter int unsigned ColW = safe_clog2(Cols)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    output logic [RowW-1:0] row,
    output logic [ColW-1:0] col,
    output logic            col_last,
    output logic            last
);

    logic [RowW-1:0] row_q, row_d;
    logic [ColW-1:0] col_q, col_d;

    assign col_last = (col_q == ColW'(Cols - 1));
    assign last     = col_last && (row_q == RowW'(Rows - 1));
    assign row      = row_q;
    assign col      = col_q;

    // Advance one element in raster order, wrapping to (0, 0) after the last one
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (en) begin
            if (col_last) begin
                col_d = '0;
                row_d = last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position registers
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/fmap_window_ctrl.sv
// Raster sequencer: inserts zero padding, drives the shift register and qualifies windows.
module fmap_window_ctrl
    import fmap_window_ctrl_pkg::*;
#(
    parameter int unsigned H        = 32,
    parameter int unsigned W        = 128,
    parameter int unsigned D        = 512,
    parameter int unsigned FH       = 3,
    parameter int unsigned FW       = 3,
    parameter int unsigned PAD      = 1,
    parameter int unsigned STRIDE_H = 1,
    parameter int unsigned STRIDE_W = 1,
    localparam int unsigned HP = padded_dim(H, PAD),
    localparam int unsigned WP = padded_dim(W, PAD),
    localparam int unsigned OH = out_dim(HP, FH, STRIDE_H),
    localparam int unsigned OW = out_dim(WP, FW, STRIDE_W),
    localparam int unsigned RW = safe_clog2(OH),
    localparam int unsigned CW = safe_clog2(OW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [D-1:0]  in_data,
    output logic          in_ready,
    output logic          sr_en,
    output logic [D-1:0]  sr_data,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          busy,
    output logic          done
);

    localparam int unsigned RCW = safe_clog2(HP);
    localparam int unsigned CCW = safe_clog2(WP);
    localparam int unsigned VPW = safe_clog2(STRIDE_H);
    localparam int unsigned HPW = safe_clog2(STRIDE_W);

    logic [1:0]     state_q, state_d;
    logic [RCW-1:0] r;
    logic [CCW-1:0] c;
    logic           c_last, rc_last;
    logic [VPW-1:0] vph_q;
    logic [HPW-1:0] hph_q;
    logic           win_valid_q, win_valid_d;
    logic           frame_clr, stall, in_run, pad_pos, qualify, handoff;
    logic           out_col_last, out_last;
    logic           unused_out_flags;

    assign frame_clr = (state_q == StIdle) && start;
    assign stall     = win_valid_q && !win_ready;
    assign in_run    = (state_q == StRun) && !stall;
    assign handoff   = win_valid_q && win_ready;
    // Compared at 32 bits so PAD+H == HP cannot alias when PAD is zero
    assign pad_pos   = (32'(r) < PAD) || (32'(r) >= PAD + H) ||
                       (32'(c) < PAD) || (32'(c) >= PAD + W);
    assign qualify   = sr_en && (32'(r) >= FH - 1) && (32'(c) >= FW - 1) &&
                       (vph_q == '0) && (hph_q == '0);

    // Shift/accept handshake, combinational so acceptance and shift share an edge
    always_comb begin
        in_ready = in_run && !pad_pos;
        sr_en    = in_run && (pad_pos || in_valid);
        sr_data  = (in_run && !pad_pos && in_valid) ? in_data : '0;
    end

    fmap_raster_cnt #(
        .Rows (HP),
        .Cols (WP),
        .RowW (RCW),
        .ColW (CCW)
    ) u_pad_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (frame_clr),
        .en       (sr_en),
        .row      (r),
        .col      (c),
        .col_last (c_last),
        .last     (rc_last)
    );

    // Output index moves on hand-off, so it always names the window currently presented
    fmap_raster_cnt #(
        .Rows (OH),
        .Cols (OW),
        .RowW (RW),
        .ColW (CW)
    ) u_out_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (frame_clr),
        .en       (handoff),
        .row      (win_row),
        .col      (win_col),
        .col_last (out_col_last),
        .last     (out_last)
    );

    assign unused_out_flags = out_col_last ^ out_last;

    // Stride phase counters replace a modulo on r and c
    always_ff @(posedge clk) begin
        if (rst || frame_clr) begin
            vph_q <= '0;
            hph_q <= '0;
        end else if (sr_en) begin
            if (c_last) begin
                hph_q <= '0;
                if (rc_last) begin
                    vph_q <= '0;
                end else if (32'(r) >= FH - 1) begin
                    vph_q <= (vph_q == VPW'(STRIDE_H - 1)) ? '0 : vph_q + 1'b1;
                end
            end else if (32'(c) >= FW - 1) begin
                hph_q <= (hph_q == HPW'(STRIDE_W - 1)) ? '0 : hph_q + 1'b1;
            end
        end
    end

    // Frame sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (sr_en && rc_last) state_d = StLast;
            StLast:  if (!win_valid_q || win_ready) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A new qualifying shift overrides a same-edge hand-off, giving back-to-back windows
    assign win_valid_d = qualify || (win_valid_q && !win_ready);

    // State and window-valid registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign win_valid = win_valid_q;
    assign busy      = (state_q == StRun) || (state_q == StLast);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_fmap_window_ctrl.sv
// Scoreboard bench for fmap_window_ctrl: padded 4x4 map with 3x3 windows, plus stride-2
// and unpadded variants.
module tb_fmap_window_ctrl;

    localparam int H  = 4;
    localparam int W  = 4;
    localparam int D  = 8;
    localparam int HP = H + 2;
    localparam int WP = W + 2;

    typedef struct {
        int row;
        int col;
        int shift;
    } win_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic [D-1:0] in_data;
    logic         in_ready;
    logic         sr_en;
    logic [D-1:0] sr_data;
    logic         win_valid;
    logic         win_ready;
    logic [1:0]   win_row;
    logic [1:0]   win_col;
    logic         busy;
    logic         done;
    logic         aux_start;

    int n_checks = 0;
    int n_errors = 0;
    int frame_id;

    // Monitor-owned state
    win_t exp_win_q[$];
    int   exp_dat_q[$];
    int   sh_cnt, acc_cnt, win_taken, done_cnt, px_idx, stall_cyc;
    int   cur_row, cur_col;
    bit   win_seen;

    fmap_window_ctrl #(
        .H(H), .W(W), .D(D), .FH(3), .FW(3), .PAD(1), .STRIDE_H(1), .STRIDE_W(1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .sr_en     (sr_en),
        .sr_data   (sr_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_row   (win_row),
        .win_col   (win_col),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [D-1:0] pix(input int f, input int i);
        return D'(f * 16 + i + 1);
    endfunction

    // Expected padded stream and window list for one stride-1 frame
    task automatic push_expect();
        int n;
        int r;
        int c;
        win_t w;
        n = 0;
        for (int k = 1; k <= HP * WP; k++) begin
            r = (k - 1) / WP;
            c = (k - 1) % WP;
            if (r < 1 || r >= 1 + H || c < 1 || c >= 1 + W) begin
                exp_dat_q.push_back(0);
            end else begin
                exp_dat_q.push_back(int'(pix(frame_id, n)));
                n++;
            end
            if (r >= 2 && c >= 2) begin
                w.row = r - 2;
                w.col = c - 2;
                w.shift = k;
                exp_win_q.push_back(w);
            end
        end
    endtask

    // Main monitor, sampled on the falling edge
    always @(negedge clk) begin
        win_t e;
        if (rst) begin
            exp_win_q.delete();
            exp_dat_q.delete();
            win_seen = 1'b0;
        end else begin
            if (start && !busy) begin
                sh_cnt = 0; acc_cnt = 0; win_taken = 0; done_cnt = 0; px_idx = 0;
                stall_cyc = 0;
            end
            if (!win_valid) win_seen = 1'b0;
            if (win_valid && !win_seen) begin
                win_seen = 1'b1;
                if (exp_win_q.size() == 0) begin
                    check_eq("win_extra", 1, 0);
                end else begin
                    e = exp_win_q.pop_front();
                    check_eq("win_row", int'(win_row), e.row);
                    check_eq("win_col", int'(win_col), e.col);
                    check_eq("win_shift", sh_cnt, e.shift);
                    cur_row = e.row;
                    cur_col = e.col;
                end
            end
            if (win_valid && !win_ready) begin
                stall_cyc++;
                check_eq("stall_sr_en", int'(sr_en), 0);
                check_eq("stall_in_ready", int'(in_ready), 0);
                check_eq("stall_row", int'(win_row), cur_row);
                check_eq("stall_col", int'(win_col), cur_col);
            end
            if (win_valid && win_ready) begin
                win_taken++;
                win_seen = 1'b0;
            end
            if (sr_en) begin
                if (exp_dat_q.size() == 0) check_eq("dat_extra", 1, 0);
                else check_eq("sr_data", int'(sr_data), exp_dat_q.pop_front());
                sh_cnt++;
            end else begin
                check_eq("sr_data_idle", int'(sr_data), 0);
            end
            if (in_ready && in_valid) begin
                acc_cnt++;
                px_idx++;
            end
        end
        if (done) done_cnt++;
    end

    // Extra geometries: g=0 stride 2 with padding, g=1 no padding
    for (genvar g = 0; g < 2; g++) begin : g_aux
        localparam int unsigned S   = (g == 0) ? 2 : 1;
        localparam int unsigned P   = (g == 0) ? 1 : 0;
        localparam int unsigned APW = 4 + 2 * P;
        localparam int unsigned AOH = (APW - 3) / S + 1;
        localparam int unsigned AW  = (AOH > 1) ? $clog2(AOH) : 1;

        logic          a_in_ready, a_sr_en, a_win_valid, a_busy, a_done;
        logic [D-1:0]  a_sr_data;
        logic [AW-1:0] a_row, a_col;
        int   nsh, nzero, nwin, ndone;
        win_t q[$];

        fmap_window_ctrl #(
            .H(4), .W(4), .D(D), .FH(3), .FW(3), .PAD(P), .STRIDE_H(S), .STRIDE_W(S)
        ) u_aux (
            .clk       (clk),
            .rst       (rst),
            .start     (aux_start),
            .in_valid  (1'b1),
            .in_data   (8'hA5),
            .in_ready  (a_in_ready),
            .sr_en     (a_sr_en),
            .sr_data   (a_sr_data),
            .win_valid (a_win_valid),
            .win_ready (1'b1),
            .win_row   (a_row),
            .win_col   (a_col),
            .busy      (a_busy),
            .done      (a_done)
        );

        always @(negedge clk) begin
            win_t e;
            int r;
            int c;
            if (aux_start && !a_busy && !rst) begin
                nsh = 0; nzero = 0; nwin = 0; ndone = 0;
                q.delete();
                for (int k = 1; k <= int'(APW * APW); k++) begin
                    r = (k - 1) / int'(APW);
                    c = (k - 1) % int'(APW);
                    if (r >= 2 && c >= 2 && (r - 2) % int'(S) == 0 && (c - 2) % int'(S) == 0) begin
                        e.row = (r - 2) / int'(S);
                        e.col = (c - 2) / int'(S);
                        e.shift = k;
                        q.push_back(e);
                    end
                end
            end
            if (!rst) begin
                if (a_win_valid) begin
                    nwin++;
                    if (q.size() == 0) begin
                        check_eq("aux_win_extra", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check_eq("aux_row", int'(a_row), e.row);
                        check_eq("aux_col", int'(a_col), e.col);
                        check_eq("aux_shift", nsh, e.shift);
                    end
                end
                if (a_sr_en) begin
                    nsh++;
                    if (a_sr_data == '0) nzero++;
                end
                if (a_done) ndone++;
            end
        end
    end

    // mode 0 plain, 1 in_valid gaps + stall on window 3, 2 start pulsed mid-frame
    task automatic run_frame(input int mode, input int abort_at);
        int stall_n;
        int cyc;
        frame_id++;
        push_expect();
        stall_n = 0;
        @(posedge clk); #1;
        in_data = pix(frame_id, 0);
        in_valid = 1'b1;
        win_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_rise", int'(busy), 1);
        for (cyc = 0; cyc < 2000; cyc++) begin
            if (abort_at != 0 && sh_cnt >= abort_at) break;
            if (done_cnt != 0) break;
            in_data  = pix(frame_id, px_idx);
            in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mode == 1 && win_valid && win_taken == 3 && stall_n < 5) begin
                win_ready = 1'b0;
                stall_n++;
            end else begin
                win_ready = 1'b1;
            end
            start = (mode == 2 && cyc == 10);
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (abort_at == 0) begin
            if (done_cnt == 0) check_eq("done_timeout", 0, 1);
            repeat (3) @(posedge clk);
            #1;
            check_eq("shifts", sh_cnt, HP * WP);
            check_eq("data_beats", acc_cnt, H * W);
            check_eq("windows", win_taken, 16);
            check_eq("done_pulses", done_cnt, 1);
            check_eq("win_q_left", exp_win_q.size(), 0);
            check_eq("dat_q_left", exp_dat_q.size(), 0);
            check_eq("busy_end", int'(busy), 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_in_ready"}, int'(in_ready), 0);
        check_eq({tag, "_sr_en"}, int'(sr_en), 0);
        check_eq({tag, "_sr_data"}, int'(sr_data), 0);
        check_eq({tag, "_win_valid"}, int'(win_valid), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_win_row"}, int'(win_row), 0);
        check_eq({tag, "_win_col"}, int'(win_col), 0);
    endtask

    initial begin
        int i;
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        win_ready = 1'b1;
        aux_start = 1'b0;
        frame_id = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        run_frame(0, 0);
        run_frame(1, 0);
        check_eq("stall_cycles", stall_cyc, 5);
        run_frame(2, 0);

        // Abandon a frame at shift 20
        run_frame(0, 20);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("midrst");
        repeat (5) @(posedge clk);
        #1;
        check_eq("abandoned_done", done_cnt, 0);
        run_frame(0, 0);

        // Alternate geometries run together
        @(posedge clk); #1;
        aux_start = 1'b1;
        @(posedge clk); #1;
        aux_start = 1'b0;
        i = 0;
        while (i < 300 && (g_aux[0].ndone == 0 || g_aux[1].ndone == 0)) begin
            @(posedge clk);
            i++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("s2_done", g_aux[0].ndone, 1);
        check_eq("s2_shifts", g_aux[0].nsh, 36);
        check_eq("s2_windows", g_aux[0].nwin, 4);
        check_eq("s2_q_left", g_aux[0].q.size(), 0);
        check_eq("p0_done", g_aux[1].ndone, 1);
        check_eq("p0_shifts", g_aux[1].nsh, 16);
        check_eq("p0_zero_beats", g_aux[1].nzero, 0);
        check_eq("p0_windows", g_aux[1].nwin, 4);
        check_eq("p0_q_left", g_aux[1].q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
